wishbone_master: RTL and testbench



---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_timeout_counter.sv | 38 +++
 rtl/wishbone_master.sv | 141 ++++++++++++++
 tb/tb_wishbone_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone message layout and FSM encoding for the initiator and the responder.
// Both sides use the same request/response field offsets.
package wb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    localparam int REQ_ADR_LSB = 0;
    localparam int REQ_ADR_MSB = ADDR_W - 1;
    localparam int REQ_DAT_LSB = ADDR_W;
    localparam int REQ_DAT_MSB = ADDR_W + DATA_W - 1;
    localparam int REQ_SEL_LSB = ADDR_W + DATA_W;
    localparam int REQ_SEL_MSB = ADDR_W + DATA_W + SEL_W - 1;
    localparam int REQ_WE_BIT  = ADDR_W + DATA_W + SEL_W;
    localparam int REQ_W       = REQ_WE_BIT + 1;

    localparam int RESP_ERR_BIT = DATA_W;
    localparam int RESP_W       = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // A disabled watchdog (timeout 0) still needs a one-bit counter to be legal.
    function automatic int counterWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts BUS cycles without ack and flags the last permitted one.
// Saturates at TIMEOUT; TIMEOUT=0 disables expiry entirely.
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CntW = counterWidth(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [CntW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CntMax)) begin
            r_count <= r_count + CntW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_noWatchdog
            assign o_expired = 1'b0;
        end else begin : g_watchdog
            assign o_expired = (r_count == CntW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wishbone_master.sv
// Wishbone classic-cycle initiator: one val/rdy request becomes one bus cycle and one response.
// A watchdog turns a missing ack into an error response so the stream never stalls.
module wishbone_master
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_val,
    output logic                                      req_rdy,
    input  logic [DATA_WIDTH/8+DATA_WIDTH+ADDR_WIDTH:0] req_msg,
    output logic                                      resp_val,
    input  logic                                      resp_rdy,
    output logic [DATA_WIDTH:0]                       resp_msg,
    output logic                                      wbm_cyc_o,
    output logic                                      wbm_stb_o,
    output logic                                      wbm_we_o,
    output logic [DATA_WIDTH/8-1:0]                   wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]                     wbm_adr_o,
    output logic [DATA_WIDTH-1:0]                     wbm_dat_o,
    input  logic                                      wbm_ack_i,
    input  logic [DATA_WIDTH-1:0]                     wbm_dat_i
);

    localparam int SelW   = DATA_WIDTH / 8;
    localparam int DatLsb = ADDR_WIDTH;
    localparam int SelLsb = ADDR_WIDTH + DATA_WIDTH;
    localparam int WeBit  = SelLsb + SelW;

    wb_state_e r_state;
    wb_state_e w_nextState;

    logic                  r_reqRdy;
    logic                  r_we;
    logic [SelW-1:0]       r_sel;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_respErr;
    logic [DATA_WIDTH-1:0] r_respData;

    logic w_accept;
    logic w_load;
    logic w_capture;
    logic w_captureErr;
    logic w_expired;
    logic w_countEn;

    assign w_accept  = (r_state == ST_IDLE) && req_val && r_reqRdy;
    assign w_countEn = (r_state == ST_BUS) && !wbm_ack_i;

    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_captureErr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = ST_BUS;
                    w_load      = 1'b1;
                end
            end
            // Ack is checked first so an ack on the expiry cycle still completes cleanly.
            ST_BUS: begin
                if (wbm_ack_i) begin
                    w_nextState = ST_RESP;
                    w_capture   = 1'b1;
                end else if (w_expired) begin
                    w_nextState  = ST_RESP;
                    w_capture    = 1'b1;
                    w_captureErr = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // req_rdy is registered so it stays low for the whole reset and rises one edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_reqRdy <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_reqRdy <= (w_nextState == ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_load) begin
            r_we  <= req_msg[WeBit];
            r_sel <= req_msg[SelLsb +: SelW];
            r_adr <= req_msg[0 +: ADDR_WIDTH];
            r_dat <= req_msg[DatLsb +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_respErr  <= 1'b0;
            r_respData <= '0;
        end else if (w_capture) begin
            r_respErr  <= w_captureErr;
            r_respData <= (w_captureErr || r_we) ? '0 : wbm_dat_i;
        end
    end

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_load),
        .i_enable  (w_countEn),
        .o_expired (w_expired)
    );

    assign req_rdy   = r_reqRdy;
    assign resp_val  = (r_state == ST_RESP);
    assign resp_msg  = {r_respErr, r_respData};
    assign wbm_cyc_o = (r_state == ST_BUS);
    assign wbm_stb_o = (r_state == ST_BUS);
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master: vector table, randomized traffic against a
// transaction-level model, and hand sequences for spurious ack and reset mid-cycle.
module tb_wishbone_master;
    import wb_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        int          waitStates;
        logic [31:0] rdata;
        int          respDelay;
        logic        expErr;
        logic [31:0] expData;
        int          expCycles;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_val;
    logic              req_rdy;
    logic [REQ_W-1:0]  req_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [31:0]       wbm_adr_o;
    logic [31:0]       wbm_dat_o;
    logic              wbm_ack_i;
    logic [31:0]       wbm_dat_i;

    int    nChecks   = 0;
    int    nErrors   = 0;
    int    respCount = 0;
    string curTag    = "init";

    wishbone_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_msg   (req_msg),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_msg  (resp_msg),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resp_val === 1'b1 && resp_rdy === 1'b1) respCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", curTag, name, actual, expected);
        end
    endtask

    // Transaction-level view: a reply arrives after waitStates wait cycles unless that
    // exceeds the watchdog window, in which case the bus gives up after TIMEOUT cycles.
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        r = v;
        r.expErr    = (v.waitStates >= TIMEOUT);
        r.expCycles = r.expErr ? TIMEOUT : v.waitStates + 1;
        r.expData   = (r.expErr || v.we) ? 32'h0 : v.rdata;
        return r;
    endfunction

    function automatic vec_t mkVec(input logic we, input logic [3:0] sel, input logic [31:0] dat,
                                   input logic [31:0] adr, input int waitStates, input logic [31:0] rdata,
                                   input int respDelay, input logic expErr, input logic [31:0] expData,
                                   input int expCycles);
        vec_t v;
        v.we = we; v.sel = sel; v.dat = dat; v.adr = adr;
        v.waitStates = waitStates; v.rdata = rdata; v.respDelay = respDelay;
        v.expErr = expErr; v.expData = expData; v.expCycles = expCycles;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int          busCycles;
        logic [32:0] expMsg;
        expMsg = {v.expErr, v.expData};
        @(negedge clk);
        checkOutput("req_rdy_before", 64'(req_rdy), 64'd1);
        req_val = 1'b1;
        req_msg = {v.we, v.sel, v.dat, v.adr};
        @(negedge clk);
        req_val = 1'b0;
        req_msg = REQ_W'({$urandom, $urandom, $urandom});
        busCycles = 0;
        while (wbm_cyc_o === 1'b1 && busCycles < 40) begin
            busCycles++;
            checkOutput("stb", 64'(wbm_stb_o), 64'd1);
            checkOutput("we", 64'(wbm_we_o), 64'(v.we));
            checkOutput("sel", 64'(wbm_sel_o), 64'(v.sel));
            checkOutput("adr", 64'(wbm_adr_o), 64'(v.adr));
            checkOutput("dat", 64'(wbm_dat_o), 64'(v.dat));
            checkOutput("req_rdy_bus", 64'(req_rdy), 64'd0);
            checkOutput("resp_val_bus", 64'(resp_val), 64'd0);
            if (busCycles == v.waitStates + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        checkOutput("bus_cycles", 64'(busCycles), 64'(v.expCycles));
        checkOutput("resp_val", 64'(resp_val), 64'd1);
        checkOutput("resp_msg", 64'(resp_msg), 64'(expMsg));
        checkOutput("req_rdy_resp", 64'(req_rdy), 64'd0);
        for (int i = 0; i < v.respDelay; i++) begin
            resp_rdy  = 1'b0;
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            @(negedge clk);
            checkOutput("resp_val_hold", 64'(resp_val), 64'd1);
            checkOutput("resp_msg_hold", 64'(resp_msg), 64'(expMsg));
            checkOutput("req_rdy_hold", 64'(req_rdy), 64'd0);
            checkOutput("cyc_hold", 64'(wbm_cyc_o), 64'd0);
        end
        wbm_ack_i = 1'b0;
        resp_rdy  = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checkOutput("resp_val_after", 64'(resp_val), 64'd0);
        checkOutput("req_rdy_after", 64'(req_rdy), 64'd1);
        checkOutput("cyc_after", 64'(wbm_cyc_o), 64'd0);
    endtask

    vec_t vecs[7];
    vec_t rv;
    int   countBefore;

    initial begin
        reset     = 1'b1;
        req_val   = 1'b0;
        req_msg   = '0;
        resp_rdy  = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;

        vecs[0] = mkVec(1'b1, 4'hF, 32'hDEADBEEF, 32'h3000_0000, 0,  32'hA5A5A5A5, 0, 1'b0, 32'h0,        1);
        vecs[1] = mkVec(1'b0, 4'hF, 32'h0,        32'h3000_0004, 3,  32'h0000_002A, 0, 1'b0, 32'h2A,       4);
        vecs[2] = mkVec(1'b0, 4'hF, 32'h0,        32'h3000_0008, 99, 32'h77,        0, 1'b1, 32'h0,        16);
        vecs[3] = mkVec(1'b1, 4'h3, 32'h12345678, 32'h3000_000C, 1,  32'h99,        0, 1'b0, 32'h0,        2);
        vecs[4] = mkVec(1'b0, 4'hF, 32'h0,        32'h3000_0010, 0,  32'h1234,      5, 1'b0, 32'h1234,     1);
        vecs[5] = mkVec(1'b0, 4'hC, 32'h0,        32'h3000_0014, 15, 32'hCAFEF00D,  1, 1'b0, 32'hCAFEF00D, 16);
        vecs[6] = mkVec(1'b1, 4'hF, 32'h11112222, 32'h3000_0018, 16, 32'h5,         0, 1'b1, 32'h0,        16);

        curTag = "reset";
        @(negedge clk);
        checkOutput("req_rdy", 64'(req_rdy), 64'd0);
        checkOutput("resp_val", 64'(resp_val), 64'd0);
        checkOutput("resp_msg", 64'(resp_msg), 64'd0);
        checkOutput("cyc", 64'(wbm_cyc_o), 64'd0);
        checkOutput("stb", 64'(wbm_stb_o), 64'd0);
        checkOutput("we", 64'(wbm_we_o), 64'd0);
        checkOutput("sel", 64'(wbm_sel_o), 64'd0);
        checkOutput("adr", 64'(wbm_adr_o), 64'd0);
        checkOutput("dat", 64'(wbm_dat_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            curTag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
        end

        for (int i = 0; i < 20; i++) begin
            curTag        = $sformatf("rand%0d", i);
            rv.we         = 1'($urandom_range(0, 1));
            rv.sel        = 4'($urandom);
            rv.dat        = $urandom;
            rv.adr        = $urandom;
            rv.waitStates = $urandom_range(0, 18);
            rv.rdata      = $urandom;
            rv.respDelay  = $urandom_range(0, 3);
            applyStimulus(refModel(rv));
        end

        curTag = "spurious";
        countBefore = respCount;
        @(negedge clk);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hBAD0BAD0;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        checkOutput("resp_val", 64'(resp_val), 64'd0);
        checkOutput("cyc", 64'(wbm_cyc_o), 64'd0);
        checkOutput("req_rdy", 64'(req_rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            curTag        = $sformatf("stream%0d", i);
            rv.we         = 1'b0;
            rv.sel        = 4'hF;
            rv.dat        = 32'h0;
            rv.adr        = 32'h3000_0100 + 32'(i * 4);
            rv.waitStates = i % 3;
            rv.rdata      = 32'h100 + 32'(i);
            rv.respDelay  = 0;
            applyStimulus(refModel(rv));
        end
        curTag = "spurious";
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_extra_resp", 64'(resp_val), 64'd0);
        end
        checkOutput("resp_count", 64'(respCount - countBefore), 64'd4);

        curTag = "midreset";
        countBefore = respCount;
        @(negedge clk);
        req_val = 1'b1;
        req_msg = {1'b0, 4'hF, 32'h0, 32'h3000_0200};
        @(negedge clk);
        req_val = 1'b0;
        checkOutput("cyc_up", 64'(wbm_cyc_o), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("cyc_async", 64'(wbm_cyc_o), 64'd0);
        checkOutput("stb_async", 64'(wbm_stb_o), 64'd0);
        checkOutput("resp_val_async", 64'(resp_val), 64'd0);
        checkOutput("req_rdy_async", 64'(req_rdy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("req_rdy_release", 64'(req_rdy), 64'd1);
        resp_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_stale_resp", 64'(resp_val), 64'd0);
        end
        resp_rdy = 1'b0;
        checkOutput("resp_count", 64'(respCount - countBefore), 64'd0);

        curTag = "post_reset";
        rv.we = 1'b0; rv.sel = 4'hF; rv.dat = 32'h0; rv.adr = 32'h3000_0204;
        rv.waitStates = 2; rv.rdata = 32'h0BADCAFE; rv.respDelay = 1;
        applyStimulus(refModel(rv));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
